cy_fifo_responder: RTL and testbench

Synthesizable FPGA-side model of the CY7C68013 synchronous slave-FIFO endpoint pair: it answers the SLRD/SLWR/SLOE/FIFOADR/PKTEND strobes the cy68013 interface logic drives and returns FX2-style flags. It lets the FX2 interface and everything behind it (SDRAM and VGA paths) run in loopback without the USB chip. A host-side byte port stands in for the USB host.

---
 rtl/cy_fifo_responder.sv | 152 +++++++++++++++
 tb/tb_cy_fifo_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cy_fifo_responder.sv
// FX2 slave-FIFO responder: EP2 (host->FPGA) and EP6 (FPGA->host) byte FIFOs.
// Ports: FX2-side strobes/flags on FD, host-side byte port, packet and error counters.
module cy_fifo_responder #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] fifoadr,
    input  logic       slrd_n,
    input  logic       slwr_n,
    input  logic       sloe_n,
    input  logic       pktend_n,
    input  logic [7:0] fd_in,
    output logic [7:0] fd_out,
    output logic       fd_oe,
    output logic       flaga_n,
    output logic       flagb_n,
    output logic       flagc_n,
    input  logic       h_wr_en,
    input  logic [7:0] h_wr_data,
    output logic       h_wr_full,
    input  logic       h_rd_en,
    output logic [7:0] h_rd_data,
    output logic       h_rd_empty,
    input  logic       h_pkt_ack,
    output logic [7:0] pkt_cnt,
    output logic       pkt_commit,
    output logic [7:0] err_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   L_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   L_CNT_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE = 1;

    logic [7:0] r_ep2_mem [DEPTH];
    logic [7:0] r_ep6_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] r_ep2_wp, r_ep2_rp;
    logic [DEPTH_LOG2-1:0] r_ep6_wp, r_ep6_rp;
    logic [DEPTH_LOG2:0]   r_ep2_cnt, r_ep6_cnt;
    logic [7:0]            r_ep2_last, r_ep6_last;
    logic [7:0]            r_pkt_cnt, r_err_cnt;
    logic                  r_pkt_commit;

    logic w_ep2_empty, w_ep2_full, w_ep6_empty, w_ep6_full;
    logic w_rd_ep2, w_wr_ep6, w_pkt_ep6;
    logic w_ep2_push, w_ep2_pop, w_ep6_push, w_ep6_pop;
    logic w_err_rd_addr, w_err_rd_empty, w_err_wr_addr, w_err_wr_full;
    logic [1:0] w_err_a, w_err_b;
    logic [8:0] w_err_sum;
    logic [7:0] w_ep2_head, w_ep6_head;

    assign w_ep2_empty = (r_ep2_cnt == '0);
    assign w_ep2_full  = (r_ep2_cnt == L_FULL);
    assign w_ep6_empty = (r_ep6_cnt == '0);
    assign w_ep6_full  = (r_ep6_cnt == L_FULL);

    assign w_rd_ep2  = ~slrd_n   & (fifoadr == 2'b00);
    assign w_wr_ep6  = ~slwr_n   & (fifoadr == 2'b10);
    assign w_pkt_ep6 = ~pktend_n & (fifoadr == 2'b10);

    // Legality uses the pre-edge count only, so a same-edge pop never
    // makes room for a push into a full FIFO (and vice versa).
    assign w_ep2_push = h_wr_en  & ~w_ep2_full;
    assign w_ep2_pop  = w_rd_ep2 & ~w_ep2_empty;
    assign w_ep6_push = w_wr_ep6 & ~w_ep6_full;
    assign w_ep6_pop  = h_rd_en  & ~w_ep6_empty;

    assign w_err_rd_addr  = ~slrd_n & (fifoadr != 2'b00);
    assign w_err_rd_empty = w_rd_ep2 & w_ep2_empty;
    assign w_err_wr_addr  = ~slwr_n & (fifoadr != 2'b10);
    assign w_err_wr_full  = w_wr_ep6 & w_ep6_full;

    assign w_err_a   = {1'b0, w_err_rd_addr} + {1'b0, w_err_rd_empty};
    assign w_err_b   = {1'b0, w_err_wr_addr} + {1'b0, w_err_wr_full};
    assign w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_err_a} + {7'd0, w_err_b};

    assign w_ep2_head = r_ep2_mem[r_ep2_rp];
    assign w_ep6_head = r_ep6_mem[r_ep6_rp];

    // Heads fall through while non-empty and freeze on the last shown byte.
    assign fd_out     = w_ep2_empty ? r_ep2_last : w_ep2_head;
    assign h_rd_data  = w_ep6_empty ? r_ep6_last : w_ep6_head;

    assign fd_oe      = ~sloe_n & (fifoadr == 2'b00);
    assign flaga_n    = ~w_ep2_empty;
    assign flagb_n    = ~w_ep6_full;
    assign flagc_n    = ~w_ep6_empty;
    assign h_wr_full  = w_ep2_full;
    assign h_rd_empty = w_ep6_empty;
    assign pkt_cnt    = r_pkt_cnt;
    assign pkt_commit = r_pkt_commit;
    assign err_cnt    = r_err_cnt;

    always_ff @(posedge sys_clk) begin
        if (w_ep2_push) r_ep2_mem[r_ep2_wp] <= h_wr_data;
        if (w_ep6_push) r_ep6_mem[r_ep6_wp] <= fd_in;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ep2_wp   <= '0;
            r_ep2_rp   <= '0;
            r_ep2_cnt  <= '0;
            r_ep2_last <= '0;
        end else begin
            if (w_ep2_push) r_ep2_wp <= r_ep2_wp + L_PTR_ONE;
            if (w_ep2_pop)  r_ep2_rp <= r_ep2_rp + L_PTR_ONE;
            if (w_ep2_push && !w_ep2_pop)
                r_ep2_cnt <= r_ep2_cnt + L_CNT_ONE;
            else if (w_ep2_pop && !w_ep2_push)
                r_ep2_cnt <= r_ep2_cnt - L_CNT_ONE;
            if (!w_ep2_empty) r_ep2_last <= w_ep2_head;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ep6_wp   <= '0;
            r_ep6_rp   <= '0;
            r_ep6_cnt  <= '0;
            r_ep6_last <= '0;
        end else begin
            if (w_ep6_push) r_ep6_wp <= r_ep6_wp + L_PTR_ONE;
            if (w_ep6_pop)  r_ep6_rp <= r_ep6_rp + L_PTR_ONE;
            if (w_ep6_push && !w_ep6_pop)
                r_ep6_cnt <= r_ep6_cnt + L_CNT_ONE;
            else if (w_ep6_pop && !w_ep6_push)
                r_ep6_cnt <= r_ep6_cnt - L_CNT_ONE;
            if (!w_ep6_empty) r_ep6_last <= w_ep6_head;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pkt_cnt    <= '0;
            r_pkt_commit <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_pkt_commit <= w_pkt_ep6;
            // Commit and ack on one edge cancel out.
            if (w_pkt_ep6 && !h_pkt_ack) begin
                if (r_pkt_cnt != 8'hFF) r_pkt_cnt <= r_pkt_cnt + 8'd1;
            end else if (h_pkt_ack && !w_pkt_ep6) begin
                if (r_pkt_cnt != 8'h00) r_pkt_cnt <= r_pkt_cnt - 8'd1;
            end
            r_err_cnt <= (w_err_sum > 9'd255) ? 8'hFF : w_err_sum[7:0];
        end
    end

endmodule

// File: tb/tb_cy_fifo_responder.sv
// Directed bench for cy_fifo_responder with byte scoreboards per endpoint.
// Ports: drives all FX2-side and host-side inputs, checks flags, heads, counters.
module tb_cy_fifo_responder;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [1:0] fifoadr;
    logic       slrd_n, slwr_n, sloe_n, pktend_n;
    logic [7:0] fd_in, fd_out;
    logic       fd_oe, flaga_n, flagb_n, flagc_n;
    logic       h_wr_en;
    logic [7:0] h_wr_data;
    logic       h_wr_full;
    logic       h_rd_en;
    logic [7:0] h_rd_data;
    logic       h_rd_empty, h_pkt_ack;
    logic [7:0] pkt_cnt;
    logic       pkt_commit;
    logic [7:0] err_cnt;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] ep2_q[$];
    logic [7:0] ep6_q[$];
    logic [7:0] exp_b;

    always #5 sys_clk = ~sys_clk;

    cy_fifo_responder #(.DEPTH_LOG2(9)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .fifoadr(fifoadr),
        .slrd_n(slrd_n), .slwr_n(slwr_n), .sloe_n(sloe_n),
        .pktend_n(pktend_n), .fd_in(fd_in), .fd_out(fd_out),
        .fd_oe(fd_oe), .flaga_n(flaga_n), .flagb_n(flagb_n),
        .flagc_n(flagc_n), .h_wr_en(h_wr_en), .h_wr_data(h_wr_data),
        .h_wr_full(h_wr_full), .h_rd_en(h_rd_en), .h_rd_data(h_rd_data),
        .h_rd_empty(h_rd_empty), .h_pkt_ack(h_pkt_ack), .pkt_cnt(pkt_cnt),
        .pkt_commit(pkt_commit), .err_cnt(err_cnt)
    );

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        sys_rst = 1'b1;
        fifoadr = 2'b11;
        slrd_n = 1'b1; slwr_n = 1'b1; sloe_n = 1'b1; pktend_n = 1'b1;
        fd_in = 8'h00; h_wr_en = 1'b0; h_wr_data = 8'h00;
        h_rd_en = 1'b0; h_pkt_ack = 1'b0;
        tick(); tick();
        sys_rst = 1'b0;
        tick();

        chk("rst_flaga", flaga_n, 1'b0);
        chk("rst_flagb", flagb_n, 1'b1);
        chk("rst_flagc", flagc_n, 1'b0);
        chk("rst_fd_out", fd_out, 8'h00);
        chk("rst_h_rd_data", h_rd_data, 8'h00);
        chk("rst_err", err_cnt, 8'd0);
        chk("rst_pkt", pkt_cnt, 8'd0);
        chk("rst_commit", pkt_commit, 1'b0);
        chk("rst_full", h_wr_full, 1'b0);
        chk("rst_empty", h_rd_empty, 1'b1);

        // Host -> EP2, FPGA reads back three bytes.
        h_wr_en = 1'b1;
        h_wr_data = 8'h11; ep2_q.push_back(8'h11); tick();
        h_wr_data = 8'h22; ep2_q.push_back(8'h22); tick();
        h_wr_data = 8'h33; ep2_q.push_back(8'h33); tick();
        h_wr_en = 1'b0;
        fifoadr = 2'b00; sloe_n = 1'b0; #1;
        chk("fd_oe_on", fd_oe, 1'b1);
        slrd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ep2_flaga_busy", flaga_n, 1'b1);
            exp_b = ep2_q.pop_front();
            chk("ep2_head", fd_out, exp_b);
            tick();
        end
        slrd_n = 1'b1;
        chk("ep2_flaga_drained", flaga_n, 1'b0);
        chk("ep2_head_hold", fd_out, 8'h33);
        chk("ep2_err", err_cnt, 8'd0);
        sloe_n = 1'b1; #1;
        chk("fd_oe_off", fd_oe, 1'b0);

        // FPGA fills EP6 to depth, overflows once, host drains.
        fifoadr = 2'b10; slwr_n = 1'b0;
        for (int i = 0; i < 512; i++) begin
            fd_in = 8'(i);
            ep6_q.push_back(8'(i));
            tick();
        end
        chk("ep6_flagb_full", flagb_n, 1'b0);
        chk("ep6_flagc_nonempty", flagc_n, 1'b1);
        fd_in = 8'hAA; tick();
        slwr_n = 1'b1;
        chk("ep6_overflow_err", err_cnt, 8'd1);
        h_rd_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            exp_b = ep6_q.pop_front();
            chk("ep6_data", h_rd_data, exp_b);
            tick();
        end
        h_rd_en = 1'b0;
        chk("ep6_flagc_drained", flagc_n, 1'b0);
        chk("ep6_h_empty", h_rd_empty, 1'b1);
        chk("ep6_head_hold", h_rd_data, 8'hFF);
        chk("ep6_flagb_free", flagb_n, 1'b1);

        // Packet commit with data, then a zero-length packet.
        slwr_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fd_in = 8'hA0 + 8'(i);
            ep6_q.push_back(8'hA0 + 8'(i));
            if (i == 3) pktend_n = 1'b0;
            tick();
        end
        slwr_n = 1'b1;
        chk("pkt1_commit", pkt_commit, 1'b1);
        chk("pkt1_cnt", pkt_cnt, 8'd1);
        tick();
        chk("zlp_commit", pkt_commit, 1'b1);
        chk("zlp_cnt", pkt_cnt, 8'd2);
        pktend_n = 1'b1; tick();
        chk("commit_low", pkt_commit, 1'b0);
        fifoadr = 2'b00; pktend_n = 1'b0; tick();
        pktend_n = 1'b1; tick();
        chk("pktend_badaddr_cnt", pkt_cnt, 8'd2);
        chk("pktend_badaddr_commit", pkt_commit, 1'b0);
        chk("pktend_badaddr_err", err_cnt, 8'd1);
        h_pkt_ack = 1'b1; tick();
        chk("ack1", pkt_cnt, 8'd1);
        fifoadr = 2'b10; pktend_n = 1'b0; tick();
        chk("ack_and_commit", pkt_cnt, 8'd1);
        pktend_n = 1'b1; tick();
        chk("ack2", pkt_cnt, 8'd0);
        tick();
        chk("ack_at_zero", pkt_cnt, 8'd0);
        h_pkt_ack = 1'b0;
        h_rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_b = ep6_q.pop_front();
            chk("pkt_data", h_rd_data, exp_b);
            tick();
        end
        h_rd_en = 1'b0;
        chk("pkt_drained", h_rd_empty, 1'b1);

        // EP2 simultaneous push/pop with one byte held.
        fifoadr = 2'b00;
        h_wr_en = 1'b1; h_wr_data = 8'h55; ep2_q.push_back(8'h55); tick();
        h_wr_data = 8'h66; ep2_q.push_back(8'h66);
        slrd_n = 1'b0;
        exp_b = ep2_q.pop_front();
        chk("pp_head_before", fd_out, exp_b);
        tick();
        slrd_n = 1'b1;
        chk("pp_flaga", flaga_n, 1'b1);
        chk("pp_head_after", fd_out, 8'h66);
        for (int i = 0; i < 511; i++) begin
            h_wr_data = 8'(i * 3);
            ep2_q.push_back(8'(i * 3));
            tick();
        end
        chk("ep2_full", h_wr_full, 1'b1);
        h_wr_data = 8'h77; slrd_n = 1'b0;
        exp_b = ep2_q.pop_front();
        chk("full_pp_head", fd_out, exp_b);
        tick();
        h_wr_en = 1'b0;
        chk("full_pp_not_full", h_wr_full, 1'b0);
        for (int i = 0; i < 511; i++) begin
            exp_b = ep2_q.pop_front();
            chk("full_pp_data", fd_out, exp_b);
            tick();
        end
        slrd_n = 1'b1;
        chk("full_pp_drained", flaga_n, 1'b0);
        chk("full_pp_err", err_cnt, 8'd1);

        // Pop from empty with a push on the same edge.
        slrd_n = 1'b0; h_wr_en = 1'b1; h_wr_data = 8'hC3; tick();
        slrd_n = 1'b1; h_wr_en = 1'b0;
        chk("pe_err", err_cnt, 8'd2);
        chk("pe_flaga", flaga_n, 1'b1);
        chk("pe_head", fd_out, 8'hC3);
        slrd_n = 1'b0; tick();
        slrd_n = 1'b1;
        chk("pe_drained", flaga_n, 1'b0);

        // Both strobes illegal on one edge, then saturate.
        h_wr_en = 1'b1; h_wr_data = 8'h99; tick();
        h_wr_en = 1'b0;
        fifoadr = 2'b01; slrd_n = 1'b0; slwr_n = 1'b0; tick();
        slrd_n = 1'b1; slwr_n = 1'b1;
        chk("double_err", err_cnt, 8'd4);
        fifoadr = 2'b10; slrd_n = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        slrd_n = 1'b1;
        fifoadr = 2'b01; slwr_n = 1'b0;
        for (int i = 0; i < 200; i++) tick();
        slwr_n = 1'b1;
        chk("err_sat", err_cnt, 8'd255);
        chk("ill_ep2_kept", flaga_n, 1'b1);
        chk("ill_ep2_head", fd_out, 8'h99);
        chk("ill_ep6_empty", flagc_n, 1'b0);
        chk("ill_ep6_notfull", flagb_n, 1'b1);

        // Reset mid-transfer clears contents.
        sys_rst = 1'b1; #2;
        chk("rst2_flaga", flaga_n, 1'b0);
        chk("rst2_err", err_cnt, 8'd0);
        chk("rst2_fd_out", fd_out, 8'h00);
        sys_rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
